// File: rtl/frac_sec_timestamp_if.sv
// Tick/PPS/snapshot bundle between the timestamp core (slave) and its driver/reader (master).
// The holdover status line exists only when FRAC_SEC_HOLDOVER_EN is defined.
interface frac_sec_timestamp_if #(
  parameter int TICK_W = 8,
  parameter int CYC_W  = 32,
  parameter int SEC_W  = 32
);
  logic              ce;
  logic              new_count;
  logic              pps_sync;
  logic              snap;
  logic              snap_valid;
  logic [SEC_W-1:0]  snap_sec;
  logic [TICK_W-1:0] snap_tick;
  logic [CYC_W-1:0]  snap_cyc;
  logic              snap_locked;
  logic [CYC_W-1:0]  period_meas;
  logic              sec_pulse;
  logic              locked;
  logic [7:0]        slip_cnt;
  logic [1:0]        state;
`ifdef FRAC_SEC_HOLDOVER_EN
  logic              holdover;
`endif

  modport master (
    output ce, new_count, pps_sync, snap,
    input  snap_valid, snap_sec, snap_tick, snap_cyc, snap_locked,
    input  period_meas, sec_pulse, locked, slip_cnt, state
`ifdef FRAC_SEC_HOLDOVER_EN
    , input holdover
`endif
  );

  modport slave (
    input  ce, new_count, pps_sync, snap,
    output snap_valid, snap_sec, snap_tick, snap_cyc, snap_locked,
    output period_meas, sec_pulse, locked, slip_cnt, state
`ifdef FRAC_SEC_HOLDOVER_EN
    , output holdover
`endif
  );
endinterface

// File: rtl/frac_sec_timestamp.sv
// Tick-driven sec/tick/cycle timestamp with PPS alignment, lock FSM and snapshot read; all outputs registered (1 cycle), no backpressure, ce stalls everything.
// Optional FRAC_SEC_HOLDOVER_EN bridges up to MAX_HOLD missing ticks with synthetic ones before declaring LOST.
module frac_sec_timestamp #(
  parameter int TICKS_PER_SEC = 100,
  parameter int TICK_W        = 8,
  parameter int CYC_W         = 32,
  parameter int SEC_W         = 32,
  parameter int TIMEOUT_CYC   = 2000000
`ifdef FRAC_SEC_HOLDOVER_EN
  , parameter int MAX_HOLD    = 4
`endif
) (
  input logic                 clk,
  input logic                 hard_rst_n,
  frac_sec_timestamp_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, ALIGN = 2'b01, RUN = 2'b10, LOST = 2'b11} state_t;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [CYC_W-1:0]  CYC_TO    = CYC_W'(TIMEOUT_CYC - 1);
  localparam logic [CYC_W-1:0]  CYC_MAX   = '1;

  state_t            r_state;
  logic [SEC_W-1:0]  r_sec;
  logic [TICK_W-1:0] r_tick;
  logic [CYC_W-1:0]  r_cyc;
  logic [CYC_W-1:0]  r_period;
  logic [7:0]        r_slip;
  logic              r_locked;
  logic              r_sec_pulse;
  logic              r_snap_valid;
  logic [SEC_W-1:0]  r_snap_sec;
  logic [TICK_W-1:0] r_snap_tick;
  logic [CYC_W-1:0]  r_snap_cyc;
  logic              r_snap_locked;
`ifdef FRAC_SEC_HOLDOVER_EN
  localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  logic [HOLD_W-1:0] r_hold;
`endif

  logic              w_wrap;
  logic [TICK_W-1:0] w_tick_adv;
  logic [SEC_W-1:0]  w_sec_inc;
  logic [CYC_W-1:0]  w_cyc_inc;
  logic [CYC_W-1:0]  w_cyc_p1;
  logic [7:0]        w_slip_inc;

  assign w_wrap     = (r_tick == TICK_LAST);
  assign w_tick_adv = w_wrap ? '0 : r_tick + TICK_W'(1);
  assign w_sec_inc  = r_sec + SEC_W'(1);
  assign w_cyc_inc  = (r_cyc == CYC_MAX) ? r_cyc : r_cyc + CYC_W'(1);
  assign w_cyc_p1   = r_cyc + CYC_W'(1);
  assign w_slip_inc = (r_slip == 8'hFF) ? r_slip : r_slip + 8'd1;

  always_ff @(posedge clk or negedge hard_rst_n) begin
    if (!hard_rst_n) begin
      r_state       <= IDLE;
      r_sec         <= '0;
      r_tick        <= '0;
      r_cyc         <= '0;
      r_period      <= '0;
      r_slip        <= '0;
      r_locked      <= 1'b0;
      r_sec_pulse   <= 1'b0;
      r_snap_valid  <= 1'b0;
      r_snap_sec    <= '0;
      r_snap_tick   <= '0;
      r_snap_cyc    <= '0;
      r_snap_locked <= 1'b0;
`ifdef FRAC_SEC_HOLDOVER_EN
      r_hold        <= '0;
`endif
    end else if (!bus.ce) begin
      r_sec_pulse  <= 1'b0;
      r_snap_valid <= 1'b0;
    end else begin
      r_sec_pulse  <= 1'b0;
      r_snap_valid <= bus.snap;
      // Snapshot sees pre-edge values, even when a tick lands on the same edge.
      if (bus.snap) begin
        r_snap_sec    <= r_sec;
        r_snap_tick   <= r_tick;
        r_snap_cyc    <= r_cyc;
        r_snap_locked <= r_locked;
      end
      case (r_state)
        IDLE: begin
          if (bus.new_count) begin
            r_state <= ALIGN;
            r_cyc   <= '0;
          end
        end
        ALIGN: begin
          r_cyc <= w_cyc_inc;
          if (bus.new_count) begin
            r_cyc    <= '0;
            r_period <= w_cyc_p1;
          end
          if (bus.pps_sync) begin
            r_state  <= RUN;
            r_locked <= 1'b1;
            r_tick   <= '0;
            r_cyc    <= '0;
          end
        end
        RUN: begin
          r_cyc <= w_cyc_inc;
          if (bus.new_count) begin
            r_period <= w_cyc_p1;
`ifdef FRAC_SEC_HOLDOVER_EN
            r_hold   <= '0;
`endif
          end
          // A PPS that coincides with the wrapping tick is the same second boundary.
          if (bus.pps_sync && !(bus.new_count && w_wrap)) begin
            r_cyc <= '0;
            if (r_tick != '0) begin
              r_tick      <= '0;
              r_sec       <= w_sec_inc;
              r_sec_pulse <= 1'b1;
              r_slip      <= w_slip_inc;
            end
          end else if (bus.new_count) begin
            r_cyc  <= '0;
            r_tick <= w_tick_adv;
            if (w_wrap) begin
              r_sec       <= w_sec_inc;
              r_sec_pulse <= 1'b1;
            end
          end else if (r_cyc == CYC_TO) begin
`ifdef FRAC_SEC_HOLDOVER_EN
            if (r_hold == HOLD_MAX) begin
              r_state  <= LOST;
              r_locked <= 1'b0;
              r_hold   <= '0;
            end else begin
              r_cyc  <= '0;
              r_tick <= w_tick_adv;
              r_hold <= r_hold + HOLD_W'(1);
              if (w_wrap) begin
                r_sec       <= w_sec_inc;
                r_sec_pulse <= 1'b1;
              end
            end
`else
            r_state  <= LOST;
            r_locked <= 1'b0;
`endif
          end
        end
        LOST: begin
          r_cyc <= w_cyc_inc;
          if (bus.new_count) begin
            r_state  <= ALIGN;
            r_cyc    <= '0;
            r_period <= w_cyc_p1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.snap_valid  = r_snap_valid;
  assign bus.snap_sec    = r_snap_sec;
  assign bus.snap_tick   = r_snap_tick;
  assign bus.snap_cyc    = r_snap_cyc;
  assign bus.snap_locked = r_snap_locked;
  assign bus.period_meas = r_period;
  assign bus.sec_pulse   = r_sec_pulse;
  assign bus.locked      = r_locked;
  assign bus.slip_cnt    = r_slip;
  assign bus.state       = r_state;
`ifdef FRAC_SEC_HOLDOVER_EN
  assign bus.holdover    = (r_hold != '0);
`endif
endmodule
